// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI-slave memory subsystem: FSM states, opcodes, widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spi_mem_pkg;

  localparam int FRAME_W_DEF = 10;  // {opcode[1:0], payload[7:0]}
  localparam int DATA_W_DEF  = 8;   // read data returned by the memory
  localparam int CNT_W_DEF   = 4;   // bit counter, must hold FRAME_W_DEF

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } spi_state_e;

  // Opcodes carried in frame bits 9:8. The front end only looks at bit 9;
  // the memory block decodes the full opcode.
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_serializer.sv
// MISO serialiser: loads a read-data byte and shifts it out MSB first.
// Latency: MSB on MISO the cycle after i_load, LSB DATA_W-1 cycles later, then 0.
// Backpressure: none; i_clr (frame abort) drops the byte and forces MISO low.
// Ports: clk, rst_n (sync, active low), i_load/i_data (byte to send),
//        i_clr (abort), o_miso (registered serial out), o_busy (shifting).
module spi_tx_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_clr,
  output logic              o_miso,
  output logic              o_busy
);

  localparam int CW = $clog2(DATA_W);

  logic [DATA_W-1:0] r_shift;
  logic [CW-1:0]     r_cnt;    // bits still to drive after the current one
  logic              r_miso;
  logic              r_busy;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_miso  <= 1'b0;
      r_busy  <= 1'b0;
    end else if (i_load) begin
      // MSB goes straight to the output register so it appears next cycle.
      r_miso  <= i_data[DATA_W-1];
      r_shift <= {i_data[DATA_W-2:0], 1'b0};
      r_cnt   <= CW'(DATA_W - 1);
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        r_miso  <= r_shift[DATA_W-1];
        r_shift <= {r_shift[DATA_W-2:0], 1'b0};
        r_cnt   <= r_cnt - 1'b1;
      end else begin
        r_miso  <= 1'b0;
        r_busy  <= 1'b0;
      end
    end
  end

  assign o_miso = r_miso;
  assign o_busy = r_busy;

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises 10-bit command frames, serialises read data on MISO.
// Latency: rx_valid 1 cycle after bit 0 is sampled; MISO MSB 1 cycle after tx_valid.
// Backpressure: none; SS_n high aborts the frame, tx_valid only honoured while awaiting read data.
// Ports: clk, rst_n (sync, active low), SS_n/MOSI (serial in), MISO (serial out),
//        rx_data/rx_valid (command word to memory), tx_data/tx_valid (read data from memory).
module spi_slave_if
  import spi_mem_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);

  spi_state_e         r_state;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [FRAME_W-2:0] r_shift;        // all frame bits but the last one
  logic [FRAME_W-1:0] r_rx_data;
  logic               r_rx_valid;
  logic               r_rd_addr_done; // a read address was sent, next read is a data read
  logic               r_tx_wait;      // READ_DATA frame done, waiting for memory

  logic w_frame_done;
  logic w_last_bit;
  logic w_tx_load;
  logic w_tx_busy;

  assign w_frame_done = (r_bit_cnt == CNT_W'(FRAME_W));
  assign w_last_bit   = (r_bit_cnt == CNT_W'(FRAME_W - 1));
  assign w_tx_load    = (r_state == READ_DATA) && r_tx_wait && !SS_n && tx_valid && !w_tx_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rd_addr_done <= 1'b0;
      r_tx_wait      <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (r_state != IDLE && SS_n) begin
        // Abort: partial frames are dropped, read-address history is kept.
        r_state   <= IDLE;
        r_bit_cnt <= '0;
        r_tx_wait <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (!SS_n) r_state <= CHK_CMD;
          end
          CHK_CMD: begin
            r_shift   <= {{(FRAME_W-2){1'b0}}, MOSI};
            r_bit_cnt <= CNT_W'(1);
            if (!MOSI)               r_state <= WRITE;
            else if (r_rd_addr_done) r_state <= READ_DATA;
            else                     r_state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!w_frame_done) begin
              r_shift   <= {r_shift[FRAME_W-3:0], MOSI};
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (w_last_bit) begin
                r_rx_data  <= {r_shift, MOSI};
                r_rx_valid <= 1'b1;
                if (r_state == READ_ADD) r_rd_addr_done <= 1'b1;
                if (r_state == READ_DATA) begin
                  r_rd_addr_done <= 1'b0;
                  r_tx_wait      <= 1'b1;
                end
              end
            end else if (w_tx_load) begin
              r_tx_wait <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  spi_tx_serializer #(
    .DATA_W (DATA_W)
  ) u_tx_ser (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_tx_load),
    .i_data (tx_data),
    .i_clr  (SS_n),
    .o_miso (MISO),
    .o_busy (w_tx_busy)
  );

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_if.sv
// Testbench for spi_slave_if: directed frames plus random frames against a frame-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int n_checks = 0;
  int n_pass   = 0;
  bit m_rd_done = 1'b0;  // model: a read address has been sent

  always #5 clk = ~clk;

  spi_slave_if dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // One frame: SS_n low for cycles 0..len, high in cycle len+1.
  // Frame bit (10-k) is on MOSI in cycle k. tx_valid pulses in cycle tx_at (if >= 0).
  // Observations after edge k belong to cycle k+1.
  task automatic run_frame(input int fid, input logic [9:0] word, input int len,
                           input int tx_at, input logic [7:0] txd);
    logic exp_rxv  [0:63];
    logic exp_miso [0:63];
    bit   complete;
    bit   rd_data_path;
    int   load_t;
    for (int i = 0; i < 64; i++) begin
      exp_rxv[i]  = 1'b0;
      exp_miso[i] = 1'b0;
    end
    complete     = (len >= 10);
    rd_data_path = complete && word[9] && m_rd_done;
    load_t       = (rd_data_path && tx_at >= 11 && tx_at <= len) ? tx_at : -1;
    if (complete) exp_rxv[11] = 1'b1;
    if (load_t >= 0)
      for (int i = 0; i < 8; i++)
        if (load_t + i <= len) exp_miso[load_t + 1 + i] = txd[7 - i];
    if (complete && word[9]) m_rd_done = !m_rd_done;

    for (int k = 0; k <= len + 1; k++) begin
      SS_n     = (k <= len) ? 1'b0 : 1'b1;
      MOSI     = (k >= 1 && k <= 10) ? word[10 - k] : 1'($urandom);
      tx_valid = (k == tx_at);
      tx_data  = (k == tx_at) ? txd : 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      check_val($sformatf("rx_valid f%0d c%0d", fid, k + 1), {31'b0, rx_valid}, {31'b0, exp_rxv[k + 1]});
      check_val($sformatf("miso f%0d c%0d", fid, k + 1), {31'b0, MISO}, {31'b0, exp_miso[k + 1]});
      if (exp_rxv[k + 1])
        check_val($sformatf("rx_data f%0d", fid), {22'b0, rx_data}, {22'b0, word});
    end
    tx_valid = 1'b0;
  endtask

  // Write frame interrupted by reset on the edge that samples bit 5.
  task automatic reset_mid(input logic [9:0] word);
    for (int k = 0; k <= 5; k++) begin
      rst_n    = (k == 5) ? 1'b0 : 1'b1;
      SS_n     = 1'b0;
      MOSI     = (k >= 1) ? word[10 - k] : 1'b0;
      tx_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_val($sformatf("rstmid rx_valid c%0d", k + 1), {31'b0, rx_valid}, 32'd0);
      check_val($sformatf("rstmid miso c%0d", k + 1), {31'b0, MISO}, 32'd0);
    end
    check_val("rstmid rx_data", {22'b0, rx_data}, 32'd0);
    rst_n = 1'b1;
    SS_n  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      MOSI = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check_val("rstmid after rx_valid", {31'b0, rx_valid}, 32'd0);
      check_val("rstmid after miso", {31'b0, MISO}, 32'd0);
    end
    m_rd_done = 1'b0;
  endtask

  initial begin
    logic [9:0] w;
    int len;
    int tx_at;
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    @(negedge clk);
    repeat (3) begin
      SS_n = 1'($urandom); MOSI = 1'($urandom); tx_valid = 1'($urandom); tx_data = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    check_val("reset rx_valid", {31'b0, rx_valid}, 32'd0);
    check_val("reset miso", {31'b0, MISO}, 32'd0);
    check_val("reset rx_data", {22'b0, rx_data}, 32'd0);
    rst_n = 1'b1; SS_n = 1'b1; tx_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);

    run_frame(1, 10'h0A5, 12, 5, 8'hFF);    // write address, stray tx_valid
    run_frame(2, 10'h13C, 10, -1, 8'h00);   // write data, minimal SS_n window
    run_frame(3, 10'h2A5, 11, -1, 8'h00);   // read address
    run_frame(4, 10'h300, 22, 12, 8'hC3);   // read data, MISO cycles 13..20
    run_frame(5, 10'h2A5, 4, -1, 8'h00);    // abort after 4 bits
    run_frame(6, 10'h3C0, 22, 12, 8'h5A);   // goes to READ_ADD: tx_valid ignored
    run_frame(7, 10'h3FF, 30, 17, 8'h96);   // read data, tx_valid 5 cycles late
    run_frame(8, 10'h2A5, 10, -1, 8'h00);   // read address again
    reset_mid(10'h0A5);
    run_frame(9, 10'h3AA, 22, 12, 8'hE7);   // reset cleared history: READ_ADD

    for (int f = 10; f < 80; f++) begin
      w   = 10'($urandom);
      len = ($urandom_range(3, 0) == 0) ? $urandom_range(9, 1) : $urandom_range(30, 10);
      tx_at = $urandom_range(len, 1);
      if (w[9] && m_rd_done && len >= 11 && $urandom_range(3, 0) != 0)
        tx_at = $urandom_range((len < 18) ? len : 18, 11);
      run_frame(f, w, len, tx_at, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
Serial front end of the SPI-slave memory subsystem. Deserialises MOSI frames into 10-bit command words (2-bit opcode + 8-bit payload) for the downstream memory block. Serialises the 8-bit read data returned by that block onto MISO. Runs on the system clock; SS_n and MOSI are sampled on rising clk edges, one bit per cycle.

Parameters:
FRAME_W, 10, width of rx_data word (opcode[1:0] + payload)
DATA_W, 8, width of returned read data shifted out on MISO
CNT_W, 4, bit-counter width (must hold FRAME_W)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous, active-low reset
SS_n  in  1  slave select, active low; frame boundary
MOSI  in  1  serial data in, MSB first
MISO  out  1  serial data out, MSB first, registered
rx_data  out  FRAME_W  assembled command word {opcode, payload} to memory
rx_valid  out  1  one-cycle strobe, rx_data valid
tx_data  in  DATA_W  read data from memory
tx_valid  in  1  tx_data valid (memory asserts after a read-data command)

Behaviour:
- Reset, with rst_n low at an edge: state=IDLE, rx_data=0, rx_valid=0, MISO=0, bit_cnt=0, rd_addr_done=0, tx shift register=0. Reset dominates all inputs.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- In every non-IDLE state, SS_n=1 at an edge -> IDLE next cycle. This aborts the frame: no rx_valid for a partial frame, bit_cnt cleared, MISO=0, rd_addr_done kept.
- IDLE: SS_n=0 -> CHK_CMD. MOSI is ignored in this cycle.
- CHK_CMD: samples frame bit 9 into the shift register; bit_cnt=1.
  - Bit 9 = 0 -> WRITE.
  - Bit 9 = 1 and rd_addr_done=0 -> READ_ADD.
  - Bit 9 = 1 and rd_addr_done=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift MOSI into the LSB each cycle until bit_cnt=FRAME_W.
  - The edge that samples bit 0 registers rx_data and drives rx_valid=1 for exactly one cycle.
  - Extra MOSI bits after a complete frame are ignored until SS_n rises.
- READ_ADD frame complete -> rd_addr_done=1.
- READ_DATA frame complete -> rd_addr_done=0. The block then waits, indefinitely while SS_n=0, for tx_valid=1.
  - On tx_valid, load tx_data into the tx shift register.
  - MISO carries bit 7..bit 0 on the next 8 cycles, then returns to 0.
  - tx_valid outside the READ_DATA wait phase is ignored.
- Latency, with cycle 0 = IDLE sampling SS_n=0:
  - bits 9..0 are sampled in cycles 1..10;
  - rx_valid is high in cycle 11;
  - memory tx_valid arrives in cycle 12;
  - MISO bit 7 is driven in cycle 13 and bit 0 in cycle 20.
- The opcode in bits 9:8 is passed through unchecked. The write path forwards both 00 (set write address) and 01 (write data). Path choice uses bit 9 only.
- Back-to-back frames need SS_n high for at least 1 cycle (an IDLE pass).
- MISO is 0 whenever the block is not serialising.

Decomposition:
- Shared package spi_mem_pkg holds:
  - the state enum;
  - opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11;
  - FRAME_W and DATA_W defaults.
- The memory block imports the same opcode constants.
- One natural sub-module: spi_tx_serializer. It covers load on tx_valid, the 8-cycle MSB-first shift and a busy flag; the FSM owns everything else.

Test Plan:
- Reset mid-frame: rst_n low during bit 5 of a write frame -> next cycle state=IDLE, rx_valid=0, MISO=0; no rx_valid is ever emitted for that frame.
- Write address: SS_n low, MOSI 00_1010_0101 -> rx_valid in cycle 11 with rx_data=10'h0A5 for exactly 1 cycle; path is WRITE.
- Write data then read address: frames 01_0011_1100 and 10_1010_0101 -> rx_data=10'h13C, then 10'h2A5; rd_addr_done=1 after the second frame.
- Read data: after a read-address frame, frame 11_0000_0000 and memory returns tx_valid with tx_data=8'hC3 in cycle 12 -> MISO = 1,1,0,0,0,0,1,1 in cycles 13..20, then 0; rd_addr_done=0.
- Abort: SS_n rises after 4 bits of a READ_ADD frame -> IDLE, no rx_valid, rd_addr_done remains 0. The next frame with bit 9=1 goes to READ_ADD again.
- Late/stray tx_valid: tx_valid pulsed during a WRITE frame -> MISO stays 0. In READ_DATA, tx_valid delayed by 5 cycles -> MISO starts exactly 1 cycle after tx_valid.
